int_arbiter: RTL and testbench

Interrupt arbiter and sequencer in front of the interrupt return/vector unit of the pipelined CPU. Captures four external request lines, prioritises them against a mask and the in-service set, waits for a safe pipeline point, then issues a one-cycle break pulse with the 2-bit interrupt code and pipeline flush strobes. Tracks in-service levels and retires them on ERET, so the downstream unit only ever sees one clean, well-timed break per accepted interrupt.

---
 rtl/int_pkg.sv | 21 ++
 rtl/int_prio_enc.sv | 27 ++
 rtl/int_arbiter.sv | 145 ++++++++++++++
 tb/tb_int_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_pkg
// Brief    : Shared types and constants for the interrupt arbiter.
// Revision : 1.0
// ============================================================================
package int_pkg;

    localparam int NUM_IRQ = 4;
    localparam int CODE_W  = 2;

    localparam logic [NUM_IRQ-1:0] C_RST_MASK = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TAKE = 2'd2
    } state_t;

endpackage : int_pkg
`default_nettype wire

// File: rtl/int_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : int_prio_enc
// Brief    : Combinational 4-to-2 highest-set-bit encoder with valid flag.
// Revision : 1.0
// ============================================================================
module int_prio_enc
    import int_pkg::*;
(
    input  logic [NUM_IRQ-1:0] in_vec,
    output logic [CODE_W-1:0]  out_idx,
    output logic               out_valid
);

    always_comb begin
        out_idx   = '0;
        out_valid = |in_vec;
        // Ascending scan so the highest set index is the last one assigned
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (in_vec[i]) begin
                out_idx = CODE_W'(i);
            end
        end
    end

endmodule : int_prio_enc
`default_nettype wire

// File: rtl/int_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : int_arbiter
// Brief    : Interrupt capture, prioritisation and break sequencing for the
//            CPU pipeline. Nesting by priority is enabled with INT_NEST_EN.
// Revision : 1.0
// ============================================================================
module int_arbiter
    import int_pkg::*;
(
    input  logic               in_CLK,
    input  logic               in_RST,
    input  logic [NUM_IRQ-1:0] in_irq,
    input  logic               in_IE,
    input  logic               in_mask_we,
    input  logic [NUM_IRQ-1:0] in_mask_wd,
    input  logic               in_stall,
    input  logic               in_eret,
    output logic               out_BK,
    output logic [CODE_W-1:0]  out_code,
    output logic               out_FDCLR,
    output logic               out_DECLR,
    output logic               out_EECLR,
    output logic [NUM_IRQ-1:0] out_pending,
    output logic [NUM_IRQ-1:0] out_IS,
    output logic [NUM_IRQ-1:0] out_mask,
    output logic               out_busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_IRQ-1:0]  r_irq_q;
    logic [NUM_IRQ-1:0]  r_pending;
    logic [NUM_IRQ-1:0]  r_is;
    logic [NUM_IRQ-1:0]  r_mask;
    logic [CODE_W-1:0]   r_win;
    logic [CODE_W-1:0]   r_code;

    logic [NUM_IRQ-1:0]  w_cand;
    logic [CODE_W-1:0]   w_cand_idx;
    logic                w_cand_valid;
    logic [CODE_W-1:0]   w_is_idx;
    logic                w_is_valid;
    logic                w_nest_ok_cand;
    logic                w_nest_ok_win;
    logic                w_cand_elig;
    logic                w_win_elig;
    logic [NUM_IRQ-1:0]  w_edge;
    logic [NUM_IRQ-1:0]  w_take_onehot;
    logic [NUM_IRQ-1:0]  w_eret_onehot;

    assign w_cand = r_pending & r_mask;
    assign w_edge = in_irq & ~r_irq_q;

    int_prio_enc u_cand_enc (
        .in_vec    (w_cand),
        .out_idx   (w_cand_idx),
        .out_valid (w_cand_valid)
    );

    int_prio_enc u_is_enc (
        .in_vec    (r_is),
        .out_idx   (w_is_idx),
        .out_valid (w_is_valid)
    );

`ifdef INT_NEST_EN
    assign w_nest_ok_cand = !w_is_valid || (w_cand_idx > w_is_idx);
    assign w_nest_ok_win  = !w_is_valid || (r_win > w_is_idx);
`else
    assign w_nest_ok_cand = !w_is_valid;
    assign w_nest_ok_win  = !w_is_valid;
`endif

    assign w_cand_elig = in_IE && w_cand_valid && w_nest_ok_cand;
    // The latched winner must still be requested, unmasked and allowed
    assign w_win_elig  = in_IE && r_pending[r_win] && r_mask[r_win] && w_nest_ok_win;

    assign w_take_onehot = (r_state == TAKE) ? (NUM_IRQ'(1) << r_code) : '0;
    assign w_eret_onehot = (in_eret && w_is_valid) ? (NUM_IRQ'(1) << w_is_idx) : '0;

    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_cand_elig) w_state_nxt = WAIT;
            WAIT: begin
                if (!w_win_elig) begin
                    w_state_nxt = IDLE;
                end else if (!in_stall) begin
                    w_state_nxt = TAKE;
                end
            end
            TAKE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_BK    = (r_state == TAKE);
        out_FDCLR = (r_state == TAKE);
        out_DECLR = (r_state == TAKE);
        out_EECLR = (r_state == TAKE);
        out_busy  = (r_state != IDLE);
    end

    // A new edge overrides the TAKE clear; ERET acts on the pre-TAKE IS set
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            r_irq_q   <= '0;
            r_pending <= '0;
            r_is      <= '0;
            r_mask    <= C_RST_MASK;
            r_win     <= '0;
            r_code    <= '0;
        end else begin
            r_irq_q   <= in_irq;
            r_pending <= (r_pending & ~w_take_onehot) | w_edge;
            r_is      <= (r_is & ~w_eret_onehot) | w_take_onehot;
            if (in_mask_we) begin
                r_mask <= in_mask_wd;
            end
            if (r_state == IDLE && w_cand_elig) begin
                r_win <= w_cand_idx;
            end
            if (r_state == WAIT && w_state_nxt == TAKE) begin
                r_code <= r_win;
            end
        end
    end

    assign out_code    = r_code;
    assign out_pending = r_pending;
    assign out_IS      = r_is;
    assign out_mask    = r_mask;

endmodule : int_arbiter
`default_nettype wire

// File: tb/tb_int_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_arbiter
// Brief    : Directed self-checking bench for int_arbiter.
// Revision : 1.0
// ============================================================================
module tb_int_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic       ie;
    logic       mask_we;
    logic [3:0] mask_wd;
    logic       stall;
    logic       eret;
    logic       bk;
    logic [1:0] code;
    logic       fdclr, declr, eeclr;
    logic [3:0] pending, is_q, mask_q;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    int_arbiter dut (
        .in_CLK      (clk),
        .in_RST      (rst),
        .in_irq      (irq),
        .in_IE       (ie),
        .in_mask_we  (mask_we),
        .in_mask_wd  (mask_wd),
        .in_stall    (stall),
        .in_eret     (eret),
        .out_BK      (bk),
        .out_code    (code),
        .out_FDCLR   (fdclr),
        .out_DECLR   (declr),
        .out_EECLR   (eeclr),
        .out_pending (pending),
        .out_IS      (is_q),
        .out_mask    (mask_q),
        .out_busy    (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bk(input int budget, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            tick();
            n++;
            if (bk === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq = 4'h0; ie = 1'b0; mask_we = 1'b0; mask_wd = 4'h0;
        stall = 1'b0; eret = 1'b0;
        tick(); tick();
        checks++; if (bk !== 1'b0) begin failures++; $display("FAIL reset_bk got=%b exp=0", bk); end
        checks++; if ({fdclr, declr, eeclr} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {fdclr, declr, eeclr}); end
        checks++; if (code !== 2'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", code); end
        checks++; if ({pending, is_q, mask_q} !== 12'h000) begin failures++; $display("FAIL reset_regs got=%h exp=000", {pending, is_q, mask_q}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0; ie = 1'b1;
        mask_we = 1'b1; mask_wd = 4'hF;
        tick();
        mask_we = 1'b0;
        checks++; if (mask_q !== 4'hF) begin failures++; $display("FAIL mask_write got=%h exp=f", mask_q); end
    endtask

    task automatic test_basic();
        irq = 4'b0010;
        tick();
        checks++; if (pending !== 4'b0010 || busy !== 1'b0) begin failures++; $display("FAIL basic_e0 got pend=%b busy=%b exp pend=0010 busy=0", pending, busy); end
        tick();
        checks++; if (busy !== 1'b1 || bk !== 1'b0) begin failures++; $display("FAIL basic_e1 got busy=%b bk=%b exp busy=1 bk=0", busy, bk); end
        tick();
        checks++; if (bk !== 1'b1 || code !== 2'd1 || {fdclr, declr, eeclr} !== 3'b111) begin failures++; $display("FAIL basic_take got bk=%b code=%0d str=%b exp 1/1/111", bk, code, {fdclr, declr, eeclr}); end
        tick();
        checks++; if (bk !== 1'b0 || is_q !== 4'b0010 || pending !== 4'b0000 || code !== 2'd1) begin failures++; $display("FAIL basic_after got bk=%b is=%b pend=%b code=%0d exp 0/0010/0000/1", bk, is_q, pending, code); end
        irq = 4'h0;
        do_eret();
        checks++; if (is_q !== 4'b0000) begin failures++; $display("FAIL basic_eret got is=%b exp=0000", is_q); end
        do_eret();
        checks++; if (is_q !== 4'b0000 || bk !== 1'b0) begin failures++; $display("FAIL eret_empty got is=%b bk=%b exp 0000/0", is_q, bk); end
    endtask

    task automatic test_edge_during_clear();
        int n; bit seen;
        irq = 4'b0010;
        tick(); tick();
        irq = 4'b0000;
        tick();
        checks++; if (bk !== 1'b1) begin failures++; $display("FAIL clr_take got bk=%b exp=1", bk); end
        irq = 4'b0010;
        tick();
        checks++; if (pending !== 4'b0010 || is_q !== 4'b0010) begin failures++; $display("FAIL clr_set_wins got pend=%b is=%b exp 0010/0010", pending, is_q); end
        irq = 4'b0000;
        wait_bk(4, n, seen);
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL same_level_blocked got bk after %0d exp none", n); end
        do_eret();
        wait_bk(6, n, seen);
        checks++; if (seen !== 1'b1 || code !== 2'd1) begin failures++; $display("FAIL reserve got seen=%b code=%0d exp 1/1", seen, code); end
        tick();
        do_eret();
        checks++; if (is_q !== 4'b0000 || pending !== 4'b0000) begin failures++; $display("FAIL reserve_done got is=%b pend=%b exp 0000/0000", is_q, pending); end
    endtask

    task automatic test_priority();
        int n; bit seen;
        irq = 4'b0101;
        tick();
        checks++; if (pending !== 4'b0101) begin failures++; $display("FAIL prio_pend got=%b exp=0101", pending); end
        tick(); tick();
        checks++; if (bk !== 1'b1 || code !== 2'd2) begin failures++; $display("FAIL prio_first got bk=%b code=%0d exp 1/2", bk, code); end
        tick();
        checks++; if (is_q !== 4'b0100 || pending !== 4'b0001) begin failures++; $display("FAIL prio_state got is=%b pend=%b exp 0100/0001", is_q, pending); end
        irq = 4'b0000;
        wait_bk(5, n, seen);
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL prio_lower_blocked got bk after %0d exp none", n); end
        do_eret();
        wait_bk(6, n, seen);
        checks++; if (seen !== 1'b1 || n !== 2 || code !== 2'd0) begin failures++; $display("FAIL prio_second got seen=%b n=%0d code=%0d exp 1/2/0", seen, n, code); end
        tick();
        checks++; if (is_q !== 4'b0001) begin failures++; $display("FAIL prio_is0 got=%b exp=0001", is_q); end
        do_eret();
    endtask

    task automatic test_stall();
        int at = 0; bit seen = 1'b0;
        irq = 4'b1000; stall = 1'b1;
        tick();
        for (int k = 1; k <= 12 && !seen; k++) begin
            tick();
            if (bk === 1'b1) begin seen = 1'b1; at = k; end
            if (k == 6) stall = 1'b0;
        end
        checks++; if (seen !== 1'b1 || at !== 7 || code !== 2'd3) begin failures++; $display("FAIL stall_delay got seen=%b at=%0d code=%0d exp 1/7/3", seen, at, code); end
        tick();
        checks++; if (is_q !== 4'b1000 || bk !== 1'b0) begin failures++; $display("FAIL stall_after got is=%b bk=%b exp 1000/0", is_q, bk); end
        irq = 4'b0000; stall = 1'b0;
        do_eret();
    endtask

    task automatic test_mask_abort();
        int n; bit seen;
        irq = 4'b0100; stall = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_wait got busy=%b exp=1", busy); end
        mask_we = 1'b1; mask_wd = 4'b1011;
        tick();
        mask_we = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || pending !== 4'b0100 || mask_q !== 4'b1011) begin failures++; $display("FAIL abort_idle got busy=%b pend=%b mask=%b exp 0/0100/1011", busy, pending, mask_q); end
        stall = 1'b0;
        wait_bk(5, n, seen);
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_masked got bk after %0d exp none", n); end
        mask_we = 1'b1; mask_wd = 4'hF;
        tick();
        mask_we = 1'b0;
        wait_bk(6, n, seen);
        checks++; if (seen !== 1'b1 || code !== 2'd2) begin failures++; $display("FAIL abort_unmask got seen=%b code=%0d exp 1/2", seen, code); end
        tick();
        irq = 4'b0000;
        do_eret();
        checks++; if (is_q !== 4'b0000 || pending !== 4'b0000) begin failures++; $display("FAIL abort_done got is=%b pend=%b exp 0000/0000", is_q, pending); end
    endtask

`ifdef INT_NEST_EN
    task automatic test_nest();
        int n; bit seen;
        irq = 4'b0010;
        wait_bk(6, n, seen);
        tick();
        checks++; if (seen !== 1'b1 || is_q !== 4'b0010) begin failures++; $display("FAIL nest_l1 got seen=%b is=%b exp 1/0010", seen, is_q); end
        irq = 4'b1000;
        wait_bk(6, n, seen);
        checks++; if (seen !== 1'b1 || code !== 2'd3) begin failures++; $display("FAIL nest_l3 got seen=%b code=%0d exp 1/3", seen, code); end
        tick();
        checks++; if (is_q !== 4'b1010) begin failures++; $display("FAIL nest_is got=%b exp=1010", is_q); end
        irq = 4'b0000;
        do_eret();
        checks++; if (is_q !== 4'b0010) begin failures++; $display("FAIL nest_eret1 got=%b exp=0010", is_q); end
        do_eret();
        checks++; if (is_q !== 4'b0000) begin failures++; $display("FAIL nest_eret2 got=%b exp=0000", is_q); end
        irq = 4'b0001;
        wait_bk(6, n, seen);
        tick();
        irq = 4'b0100;
        wait_bk(6, n, seen);
        checks++; if (seen !== 1'b1 || code !== 2'd2) begin failures++; $display("FAIL nest_l2 got seen=%b code=%0d exp 1/2", seen, code); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        checks++; if (is_q !== 4'b0100) begin failures++; $display("FAIL nest_eret_take got=%b exp=0100", is_q); end
        irq = 4'b0000;
        do_eret();
    endtask
`endif

    task automatic test_rst_take();
        irq = 4'b0001;
        tick(); tick(); tick();
        checks++; if (bk !== 1'b1) begin failures++; $display("FAIL rst_take_bk got=%b exp=1", bk); end
        rst = 1'b1;
        tick();
        checks++; if ({bk, fdclr, declr, eeclr, busy} !== 5'b0 || code !== 2'd0) begin failures++; $display("FAIL rst_take_out got bk/str/busy=%b code=%0d exp 00000/0", {bk, fdclr, declr, eeclr, busy}, code); end
        checks++; if ({pending, is_q, mask_q} !== 12'h000) begin failures++; $display("FAIL rst_take_regs got=%h exp=000", {pending, is_q, mask_q}); end
        rst = 1'b0; irq = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_during_clear();
        test_priority();
        test_stall();
        test_mask_abort();
`ifdef INT_NEST_EN
        test_nest();
`endif
        test_rst_take();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_int_arbiter
`default_nettype wire
